pb_interrupt_controller: RTL and testbench

//  Port-mapped interrupt controller on the Picoblaze I/O bus. Collects up to 8 peripheral

---
 rtl/pb_interrupt_controller_pkg.sv | 29 ++
 rtl/pb_intc_priority_enc.sv | 20 ++
 rtl/pb_interrupt_controller.sv | 159 +++++++++++++++
 tb/tb_pb_interrupt_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pb_interrupt_controller_pkg.sv
// Shared definitions for the Picoblaze interrupt controller: register
// offsets, FSM state encoding, CONTROL bit positions and a source-mask helper.
package pb_interrupt_controller_pkg;

   // Register offsets from INTC_BASE_ADDRESS
   localparam logic [1:0] INTC_PENDING = 2'd0;
   localparam logic [1:0] INTC_MASK    = 2'd1;
   localparam logic [1:0] INTC_VECTOR  = 2'd2;
   localparam logic [1:0] INTC_CONTROL = 2'd3;

   // CONTROL register bit positions
   localparam int CTRL_GIE_BIT        = 0;
   localparam int CTRL_IN_SERVICE_BIT = 1;

   // Request/service state machine
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } intc_state_t;

   // Bits of an 8-bit register that correspond to implemented sources
   function automatic logic [7:0] src_mask(input int num_sources);
      logic [15:0] m;
      m = (16'd1 << num_sources) - 16'd1;
      return m[7:0];
   endfunction

endpackage

// File: rtl/pb_intc_priority_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module pb_intc_priority_enc (
   input  logic [7:0] req,
   output logic [2:0] id,
   output logic       valid
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      id    = 3'd0;
      valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) begin
            id    = 3'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pb_interrupt_controller.sv
// Port-mapped interrupt controller on the Picoblaze I/O bus.
// Latches rising edges of peripheral lines as pending, applies per-source
// masking and fixed lowest-index priority, and runs the CPU interrupt /
// interrupt_ack handshake, holding off further requests until firmware
// writes VECTOR (end-of-interrupt).
//
// Handshake: interrupt rises when the FSM enters ASSERT and stays high until
// the clock edge where interrupt_ack is sampled high; that edge clears the
// serviced PENDING bit and moves to SERVICE, where nothing new is requested
// until a write to VECTOR returns to IDLE.
//
// fsm_state exposes the internal state encoding for observation.
module pb_interrupt_controller
   import pb_interrupt_controller_pkg::*;
#(
   parameter logic [7:0] INTC_BASE_ADDRESS = 8'h10,
   parameter int         NUM_SOURCES       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             port_id,
   input  logic [7:0]             data_in,
   input  logic                   write_strobe,
   input  logic                   read_strobe,
   output logic [7:0]             data_out,
   input  logic [NUM_SOURCES-1:0] irq_in,
   output logic                   interrupt,
   input  logic                   interrupt_ack,
   output logic [1:0]             fsm_state
);

   localparam logic [7:0] SRC_MASK = src_mask(NUM_SOURCES);

   intc_state_t state, state_next;

   logic [7:0] irq_ext;
   logic [7:0] irq_d;
   logic [7:0] rise;
   logic [7:0] pending;
   logic [7:0] mask;
   logic [2:0] vector;
   logic       gie;

   logic [8:0] addr_diff;
   logic       hit;
   logic [1:0] reg_sel;
   logic       wr_pending;
   logic       wr_mask;
   logic       wr_vector;
   logic       wr_control;

   logic [2:0] enc_id;
   logic       enc_valid;
   logic       latch_vec;
   logic       ack_clr;
   logic [7:0] ack_bits;
   logic [7:0] w1c_bits;

   // Reads have no side effects; the strobe is accepted but unused.
   logic unused_read_strobe;
   assign unused_read_strobe = read_strobe;

   // Widen irq_in to 8 bits; unimplemented sources stay 0
   always_comb begin
      irq_ext = 8'h00;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         irq_ext[i] = irq_in[i];
      end
   end

   assign rise = irq_ext & ~irq_d;

   // Address decode: a port below the base wraps to a large 9-bit difference
   assign addr_diff  = {1'b0, port_id} - {1'b0, INTC_BASE_ADDRESS};
   assign hit        = (addr_diff < 9'd4);
   assign reg_sel    = addr_diff[1:0];
   assign wr_pending = write_strobe && hit && (reg_sel == INTC_PENDING);
   assign wr_mask    = write_strobe && hit && (reg_sel == INTC_MASK);
   assign wr_vector  = write_strobe && hit && (reg_sel == INTC_VECTOR);
   assign wr_control = write_strobe && hit && (reg_sel == INTC_CONTROL);

   pb_intc_priority_enc u_enc (
      .req   (pending & mask),
      .id    (enc_id),
      .valid (enc_valid)
   );

   assign w1c_bits  = wr_pending ? data_in : 8'h00;
   assign ack_bits  = ack_clr ? (8'd1 << vector) : 8'h00;
   assign fsm_state = state;

   // FSM next-state and handshake outputs
   always_comb begin
      state_next = state;
      latch_vec  = 1'b0;
      ack_clr    = 1'b0;
      interrupt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (gie && enc_valid) begin
               latch_vec  = 1'b1;
               state_next = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            // GIE/MASK changes do not withdraw a request already raised
            interrupt = 1'b1;
            if (interrupt_ack) begin
               ack_clr    = 1'b1;
               state_next = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            if (wr_vector) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Edge detector history, pending (new edges win over clears), mask, vector, GIE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_d   <= 8'h00;
         pending <= 8'h00;
         mask    <= 8'h00;
         vector  <= 3'd0;
         gie     <= 1'b0;
      end else begin
         irq_d   <= irq_ext;
         pending <= ((pending & ~w1c_bits & ~ack_bits) | rise) & SRC_MASK;
         if (wr_mask)    mask   <= data_in & SRC_MASK;
         if (wr_control) gie    <= data_in[CTRL_GIE_BIT];
         if (latch_vec)  vector <= enc_id;
      end
   end

   // Registered read mux; zero whenever this block is not addressed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out <= 8'h00;
      end else if (!hit) begin
         data_out <= 8'h00;
      end else begin
         case (reg_sel)
            INTC_PENDING: data_out <= pending;
            INTC_MASK:    data_out <= mask;
            INTC_VECTOR:  data_out <= {5'b00000, vector};
            default:      data_out <= {6'b000000, (state == ST_SERVICE), gie};
         endcase
      end
   end

endmodule

// File: tb/tb_pb_interrupt_controller.sv
// Self-checking bench for pb_interrupt_controller: register reads go through
// an expected-value queue, interrupt line checks go straight to check_val.
module tb_pb_interrupt_controller;
   import pb_interrupt_controller_pkg::*;

   localparam logic [7:0] BASE = 8'h10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic       write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] data_out;
   logic [7:0] irq_in = 8'h00;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;
   logic [1:0] fsm_state;

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;

   pb_interrupt_controller #(.INTC_BASE_ADDRESS(BASE), .NUM_SOURCES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .port_id       (port_id),
      .data_in       (data_in),
      .write_strobe  (write_strobe),
      .read_strobe   (read_strobe),
      .data_out      (data_out),
      .irq_in        (irq_in),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .fsm_state     (fsm_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic reg_write(input logic [1:0] off, input logic [7:0] val);
      @(negedge clk);
      port_id = BASE + 8'(off);
      data_in = val;
      write_strobe = 1'b1;
      @(posedge clk); #1;
      write_strobe = 1'b0;
      port_id = 8'h00;
   endtask

   // Push expectation, present the address, sample the registered result
   task automatic port_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      logic [7:0] e;
      exp_q.push_back(exp);
      @(negedge clk);
      port_id = addr;
      read_strobe = 1'b1;
      @(posedge clk); #1;
      read_strobe = 1'b0;
      port_id = 8'h00;
      e = exp_q.pop_front();
      check_val(tag, data_out, e);
   endtask

   task automatic pulse_irq(input int idx);
      @(negedge clk);
      irq_in[idx] = 1'b1;
      @(negedge clk);
      irq_in[idx] = 1'b0;
   endtask

   task automatic do_ack();
      @(negedge clk);
      interrupt_ack = 1'b1;
      @(posedge clk); #1;
      interrupt_ack = 1'b0;
   endtask

   // Wait up to budget edges for interrupt to rise
   task automatic wait_irq(input string tag, input int budget);
      logic seen;
      seen = interrupt;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk); #1;
         seen = interrupt;
      end
      check_val(tag, {7'b0, seen}, 8'h01);
   endtask

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // 1. reset state
      check_val("rst_interrupt", {7'b0, interrupt}, 8'h00);
      check_val("rst_data_out", data_out, 8'h00);
      port_read("rst_pending", BASE + 8'd0, 8'h00);
      port_read("rst_mask",    BASE + 8'd1, 8'h00);
      port_read("rst_vector",  BASE + 8'd2, 8'h00);
      port_read("rst_control", BASE + 8'd3, 8'h00);

      // 2. priority: sources 3 and 2 pending, enable last
      reg_write(INTC_MASK, 8'h0C);
      pulse_irq(3);
      pulse_irq(2);
      port_read("t2_pending", BASE + 8'd0, 8'h0C);
      check_val("t2_no_irq_gie0", {7'b0, interrupt}, 8'h00);
      reg_write(INTC_CONTROL, 8'h01);
      wait_irq("t2_irq_first", 3);
      port_read("t2_vector_2", BASE + 8'd2, 8'h02);
      do_ack();
      check_val("t2_irq_after_ack", {7'b0, interrupt}, 8'h00);
      port_read("t2_pending_after_ack", BASE + 8'd0, 8'h08);
      port_read("t2_control_in_service", BASE + 8'd3, 8'h03);
      repeat (3) @(posedge clk);
      #1 check_val("t2_held_off_in_service", {7'b0, interrupt}, 8'h00);
      reg_write(INTC_VECTOR, 8'hA5);
      wait_irq("t2_irq_after_eoi", 3);
      port_read("t2_vector_3", BASE + 8'd2, 8'h03);
      do_ack();
      reg_write(INTC_VECTOR, 8'h00);
      repeat (3) @(posedge clk);
      #1 check_val("t2_idle_no_work", {7'b0, interrupt}, 8'h00);
      check_val("t2_state_idle", {6'b0, fsm_state}, {6'b0, ST_IDLE});

      // 3. masked source, then unmask
      reg_write(INTC_MASK, 8'h00);
      pulse_irq(5);
      port_read("t3_pending", BASE + 8'd0, 8'h20);
      check_val("t3_masked_no_irq", {7'b0, interrupt}, 8'h00);
      reg_write(INTC_MASK, 8'h20);
      wait_irq("t3_irq_unmask", 2);
      port_read("t3_vector_5", BASE + 8'd2, 8'h05);
      do_ack();
      reg_write(INTC_VECTOR, 8'h00);

      // 4. set beats clear
      reg_write(INTC_MASK, 8'h00);
      pulse_irq(1);
      port_read("t4_pending_set", BASE + 8'd0, 8'h02);
      @(negedge clk);
      irq_in[1] = 1'b1;
      port_id = BASE;
      data_in = 8'h02;
      write_strobe = 1'b1;
      @(posedge clk); #1;
      write_strobe = 1'b0;
      port_id = 8'h00;
      @(negedge clk);
      irq_in[1] = 1'b0;
      port_read("t4_set_beats_clear", BASE + 8'd0, 8'h02);
      reg_write(INTC_PENDING, 8'h02);
      port_read("t4_w1c", BASE + 8'd0, 8'h00);

      // 6. unmapped reads, VECTOR write in IDLE
      pulse_irq(4);
      port_read("t6_pending", BASE + 8'd0, 8'h10);
      port_read("t6_base_plus4", BASE + 8'd4, 8'h00);
      port_read("t6_below_base", 8'h0F, 8'h00);
      port_read("t6_port_ff", 8'hFF, 8'h00);
      reg_write(INTC_PENDING, 8'h10);
      reg_write(INTC_VECTOR, 8'h07);
      check_val("t6_vec_write_idle_state", {6'b0, fsm_state}, {6'b0, ST_IDLE});
      port_read("t6_vector_unchanged", BASE + 8'd2, 8'h05);
      port_read("t6_control", BASE + 8'd3, 8'h01);

      // 5. GIE drop does not withdraw, reset does
      reg_write(INTC_MASK, 8'h01);
      pulse_irq(0);
      wait_irq("t5_irq", 3);
      reg_write(INTC_CONTROL, 8'h00);
      for (int i = 0; i < 3; i++) begin
         check_val("t5_irq_held", {7'b0, interrupt}, 8'h01);
         @(posedge clk); #1;
      end
      do_ack();
      check_val("t5_irq_dropped_on_ack", {7'b0, interrupt}, 8'h00);
      reg_write(INTC_VECTOR, 8'h00);
      reg_write(INTC_CONTROL, 8'h01);
      pulse_irq(0);
      wait_irq("t5_irq_again", 3);
      @(negedge clk);
      reset = 1'b1;
      #1 check_val("t5_async_reset_irq", {7'b0, interrupt}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      port_read("t5_pending_rst", BASE + 8'd0, 8'h00);
      port_read("t5_mask_rst",    BASE + 8'd1, 8'h00);
      port_read("t5_vector_rst",  BASE + 8'd2, 8'h00);
      port_read("t5_control_rst", BASE + 8'd3, 8'h00);

      check_val("scoreboard_empty", 8'(exp_q.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
